// File: rtl/reg_writeback_unit.sv
// Register file write side: writeback results queue in an in-order FIFO and
// commit one per cycle into a 32-entry array that feeds two async read ports.
module reg_writeback_unit #(
  parameter int unsigned DEPTH          = 4,
  parameter int unsigned WIDTH          = 32,
  parameter bit          ZERO_HARDWIRED = 1'b0
) (
  input  logic                     CLK,
  input  logic                     RESET_N,
  input  logic                     WB_VALID,
  output logic                     WB_READY,
  input  logic [4:0]               WB_REG,
  input  logic [WIDTH-1:0]         WB_DATA,
  input  logic                     DRAIN_EN,
  input  logic [4:0]               ReadReg1,
  input  logic [4:0]               ReadReg2,
  output logic [WIDTH-1:0]         A,
  output logic [WIDTH-1:0]         B,
  output logic                     HAZARD_A,
  output logic                     HAZARD_B,
  output logic [$clog2(DEPTH):0]   FIFO_COUNT
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [WIDTH-1:0] regs_q      [32];
  logic [WIDTH-1:0] regs_d      [32];
  logic [4:0]       fifo_reg_q  [DEPTH];
  logic [4:0]       fifo_reg_d  [DEPTH];
  logic [WIDTH-1:0] fifo_data_q [DEPTH];
  logic [WIDTH-1:0] fifo_data_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [DEPTH-1:0] entry_valid;
  logic             push, commit;
  logic [4:0]       head_reg;

  assign WB_READY   = (count_q != FULL_CNT);
  assign FIFO_COUNT = count_q;
  assign push       = WB_VALID && WB_READY;
  assign commit     = DRAIN_EN && (count_q != '0);
  assign head_reg   = fifo_reg_q[rd_ptr_q];

  always_comb begin
    regs_d      = regs_q;
    fifo_reg_d  = fifo_reg_q;
    fifo_data_d = fifo_data_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    if (push) begin
      fifo_reg_d[wr_ptr_q]  = WB_REG;
      fifo_data_d[wr_ptr_q] = WB_DATA;
      wr_ptr_d              = wr_ptr_q + PTR_ONE;
    end
    if (commit) begin
      if (!(ZERO_HARDWIRED && (head_reg == 5'd0))) begin
        regs_d[head_reg] = fifo_data_q[rd_ptr_q];
      end
      rd_ptr_d = rd_ptr_q + PTR_ONE;
    end
    case ({push, commit})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
  end

  // A slot is live when its distance from the head (mod DEPTH) is below the count.
  always_comb begin
    entry_valid = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      entry_valid[i] = ({1'b0, PTR_W'(PTR_W'(i) - rd_ptr_q)} < count_q);
    end
  end

  always_comb begin
    HAZARD_A = 1'b0;
    HAZARD_B = 1'b0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (entry_valid[i] && (fifo_reg_q[i] == ReadReg1)) HAZARD_A = 1'b1;
      if (entry_valid[i] && (fifo_reg_q[i] == ReadReg2)) HAZARD_B = 1'b1;
    end
    if (ZERO_HARDWIRED && (ReadReg1 == 5'd0)) HAZARD_A = 1'b0;
    if (ZERO_HARDWIRED && (ReadReg2 == 5'd0)) HAZARD_B = 1'b0;
  end

  always_comb begin
    A = regs_q[ReadReg1];
    B = regs_q[ReadReg2];
    if (ZERO_HARDWIRED && (ReadReg1 == 5'd0)) A = '0;
    if (ZERO_HARDWIRED && (ReadReg2 == 5'd0)) B = '0;
  end

  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      for (int unsigned i = 0; i < 32; i++) regs_q[i] <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        fifo_reg_q[i]  <= '0;
        fifo_data_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      regs_q      <= regs_d;
      fifo_reg_q  <= fifo_reg_d;
      fifo_data_q <= fifo_data_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
    end
  end

endmodule

// File: tb/tb_reg_writeback_unit.sv
// Scoreboard bench for reg_writeback_unit: directed stimulus queues expected
// observations tagged with a cycle; a negedge monitor pops and compares them.
module tb_reg_writeback_unit;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned WIDTH = 32;

  logic             clk = 1'b0;
  logic             reset_n;
  logic             wb_valid;
  logic [4:0]       wb_reg;
  logic [WIDTH-1:0] wb_data;
  logic             drain_en;
  logic [4:0]       read_reg1, read_reg2;

  logic             ready0, ready1;
  logic [WIDTH-1:0] a0, b0, a1, b1;
  logic             hza0, hzb0, hza1, hzb1;
  logic [2:0]       cnt0, cnt1;

  reg_writeback_unit #(.DEPTH(DEPTH), .WIDTH(WIDTH), .ZERO_HARDWIRED(1'b0)) dut (
    .CLK(clk), .RESET_N(reset_n), .WB_VALID(wb_valid), .WB_READY(ready0),
    .WB_REG(wb_reg), .WB_DATA(wb_data), .DRAIN_EN(drain_en),
    .ReadReg1(read_reg1), .ReadReg2(read_reg2), .A(a0), .B(b0),
    .HAZARD_A(hza0), .HAZARD_B(hzb0), .FIFO_COUNT(cnt0)
  );

  reg_writeback_unit #(.DEPTH(DEPTH), .WIDTH(WIDTH), .ZERO_HARDWIRED(1'b1)) dut_zh (
    .CLK(clk), .RESET_N(reset_n), .WB_VALID(wb_valid), .WB_READY(ready1),
    .WB_REG(wb_reg), .WB_DATA(wb_data), .DRAIN_EN(drain_en),
    .ReadReg1(read_reg1), .ReadReg2(read_reg2), .A(a1), .B(b1),
    .HAZARD_A(hza1), .HAZARD_B(hzb1), .FIFO_COUNT(cnt1)
  );

  always #5 clk = ~clk;

  typedef enum int {S_A, S_B, S_HZA, S_HZB, S_CNT, S_RDY, S_ZA, S_ZHZA, S_ZCNT} sel_e;

  typedef struct {
    string       name;
    int          cyc;
    sel_e        sel;
    logic [31:0] exp;
  } exp_t;

  exp_t sb[$];
  int   cyc    = 0;
  int   checks = 0;
  int   passed = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] actual(sel_e s);
    case (s)
      S_A:    return a0;
      S_B:    return b0;
      S_HZA:  return {31'd0, hza0};
      S_HZB:  return {31'd0, hzb0};
      S_CNT:  return {29'd0, cnt0};
      S_RDY:  return {31'd0, ready0};
      S_ZA:   return a1;
      S_ZHZA: return {31'd0, hza1};
      default: return {29'd0, cnt1};
    endcase
  endfunction

  // Monitor: compares every expectation tagged for the current cycle.
  always @(negedge clk) begin
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].cyc == cyc) begin
        logic [31:0] act;
        act = actual(sb[i].sel);
        checks++;
        if (act === sb[i].exp) passed++;
        else $display("FAIL %s @cycle %0d: got 0x%0h expected 0x%0h",
                      sb[i].name, cyc, act, sb[i].exp);
        sb.delete(i);
      end
    end
  end

  task automatic expect_now(string name, sel_e s, logic [31:0] v);
    exp_t e;
    e.name = name; e.cyc = cyc; e.sel = s; e.exp = v;
    sb.push_back(e);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset_n = 1'b0; wb_valid = 1'b0; wb_reg = '0; wb_data = '0;
    drain_en = 1'b0; read_reg1 = 5'd0; read_reg2 = 5'd0;
    step(); step();
    expect_now("rst_count", S_CNT, 0);
    expect_now("rst_ready", S_RDY, 1);
    expect_now("rst_A", S_A, 0);
    expect_now("rst_hzA", S_HZA, 0);
    expect_now("rst_hzB", S_HZB, 0);
    reset_n = 1'b1;
    step();

    // Single push/commit latency
    wb_valid = 1'b1; wb_reg = 5'd2; wb_data = 32'h1; drain_en = 1'b1; read_reg1 = 5'd2;
    expect_now("t1_pre_hzA", S_HZA, 0);
    step();
    wb_valid = 1'b0;
    expect_now("t1_push_hzA", S_HZA, 1);
    expect_now("t1_push_A", S_A, 0);
    expect_now("t1_push_cnt", S_CNT, 1);
    step();
    expect_now("t1_commit_A", S_A, 32'h1);
    expect_now("t1_commit_hzA", S_HZA, 0);
    expect_now("t1_commit_cnt", S_CNT, 0);

    // Fill to full with drain held off, then a held fifth request
    drain_en = 1'b0; wb_valid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      wb_reg = 5'(3 + k); wb_data = 32'hA + 32'(k);
      step();
    end
    wb_reg = 5'd7; wb_data = 32'hE;
    expect_now("t2_full_cnt", S_CNT, 4);
    expect_now("t2_full_rdy", S_RDY, 0);
    step();
    expect_now("t2_held_cnt", S_CNT, 4);
    drain_en = 1'b1;
    expect_now("t2_rdy_ignores_drain", S_RDY, 0);
    step();
    expect_now("t2_first_commit_cnt", S_CNT, 3);
    expect_now("t2_rdy_back", S_RDY, 1);
    step();
    wb_valid = 1'b0;
    expect_now("t2_push_commit_cnt", S_CNT, 3);
    step(); step(); step();
    expect_now("t2_drained_cnt", S_CNT, 0);
    read_reg1 = 5'd3; read_reg2 = 5'd4;
    expect_now("t2_R3", S_A, 32'hA);
    expect_now("t2_R4", S_B, 32'hB);
    step();
    read_reg1 = 5'd5; read_reg2 = 5'd6;
    expect_now("t2_R5", S_A, 32'hC);
    expect_now("t2_R6", S_B, 32'hD);
    step();
    read_reg1 = 5'd7; read_reg2 = 5'd7;
    expect_now("t2_R7_A", S_A, 32'hE);
    expect_now("t2_R7_B", S_B, 32'hE);
    step();

    // Back-to-back writes to one register, last one wins
    drain_en = 1'b1; read_reg2 = 5'd9;
    wb_valid = 1'b1; wb_reg = 5'd9; wb_data = 32'h5;
    expect_now("t3_B0", S_B, 0);
    expect_now("t3_hzB0", S_HZB, 0);
    step();
    wb_data = 32'h7;
    expect_now("t3_B1", S_B, 0);
    expect_now("t3_hzB1", S_HZB, 1);
    step();
    wb_valid = 1'b0;
    expect_now("t3_B2", S_B, 32'h5);
    expect_now("t3_hzB2", S_HZB, 1);
    expect_now("t3_cnt2", S_CNT, 1);
    step();
    expect_now("t3_B3", S_B, 32'h7);
    expect_now("t3_hzB3", S_HZB, 0);
    expect_now("t3_cnt3", S_CNT, 0);

    // Steady two-deep occupancy with wrap: entry j commits at the edge that pushes j+2
    drain_en = 1'b0; wb_valid = 1'b1;
    wb_reg = 5'd10; wb_data = 32'h100;
    step();
    expect_now("t4_cnt_k0", S_CNT, 1);
    wb_reg = 5'd11; wb_data = 32'h101;
    step();
    expect_now("t4_cnt_k1", S_CNT, 2);
    for (int j = 2; j <= 12; j++) begin
      wb_valid = (j <= 10);
      wb_reg   = 5'(10 + j);
      wb_data  = 32'h100 + 32'(j);
      drain_en = 1'b1;
      step();
      read_reg1 = 5'(10 + j - 2);
      expect_now($sformatf("t4_commit_%0d", j - 2), S_A, 32'h100 + 32'(j - 2));
      expect_now($sformatf("t4_cnt_%0d", j), S_CNT, (j <= 10) ? 2 : 32'(12 - j));
    end
    wb_valid = 1'b0;

    // Reset discards pending entries
    drain_en = 1'b0; wb_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      wb_reg = 5'(21 + k); wb_data = 32'h21 + 32'(k);
      step();
    end
    wb_valid = 1'b0;
    expect_now("t5_pending_cnt", S_CNT, 3);
    reset_n = 1'b0;
    step();
    read_reg1 = 5'd3; read_reg2 = 5'd21;
    expect_now("t5_rst_cnt", S_CNT, 0);
    expect_now("t5_rst_rdy", S_RDY, 1);
    expect_now("t5_rst_R3", S_A, 0);
    expect_now("t5_rst_hzB", S_HZB, 0);
    reset_n = 1'b1; drain_en = 1'b1;
    step(); step();
    read_reg1 = 5'd21; read_reg2 = 5'd22;
    expect_now("t5_no_commit_R21", S_A, 0);
    expect_now("t5_no_commit_R22", S_B, 0);
    expect_now("t5_no_commit_cnt", S_CNT, 0);
    step();

    // Register 0 with and without hardwiring
    read_reg1 = 5'd0; drain_en = 1'b1;
    wb_valid = 1'b1; wb_reg = 5'd0; wb_data = 32'hFFFF;
    expect_now("t6_zh_A_pre", S_ZA, 0);
    step();
    wb_valid = 1'b0;
    expect_now("t6_zh_hzA_push", S_ZHZA, 0);
    expect_now("t6_zh_cnt_push", S_ZCNT, 1);
    expect_now("t6_zh_A_push", S_ZA, 0);
    expect_now("t6_nz_hzA_push", S_HZA, 1);
    step();
    expect_now("t6_zh_A_commit", S_ZA, 0);
    expect_now("t6_zh_hzA_commit", S_ZHZA, 0);
    expect_now("t6_zh_cnt_commit", S_ZCNT, 0);
    expect_now("t6_nz_A_commit", S_A, 32'hFFFF);
    step(); step();

    checks++;
    if (cnt0 === 3'd0) passed++;
    else $display("FAIL final_cnt0: got %0d expected 0", cnt0);
    checks++;
    if (ready0 === 1'b1) passed++;
    else $display("FAIL final_ready0: got %0b expected 1", ready0);
    checks++;
    if (cnt1 === 3'd0) passed++;
    else $display("FAIL final_cnt1: got %0d expected 0", cnt1);
    checks++;
    if (a0 === 32'hFFFF) passed++;
    else $display("FAIL final_nz_A: got 0x%0h expected 0xffff", a0);
    checks++;
    if (a1 === 32'h0) passed++;
    else $display("FAIL final_zh_A: got 0x%0h expected 0x0", a1);

    while (sb.size() > 0) begin
      checks++;
      $display("FAIL unchecked_%s: got none expected 0x%0h", sb[0].name, sb[0].exp);
      void'(sb.pop_front());
    end
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/reg_writeback_unit.md
Name: reg_writeback_unit

Overview:
- Write side of the datapath register file: accepts writeback results (destination register and data) over a valid/ready handshake.
- Buffers results in a small in-order FIFO and commits them one per cycle into a 32-entry register array.
- Provides the two asynchronous read ports (A/B) feeding the ALU, plus per-port hazard flags for reads whose register still has an uncommitted write.
- Sits between the ALU/result path and the operand-fetch stage, replacing the read-only register file.

Parameters:
DEPTH, 4, writeback FIFO depth; power of two, at least 2
WIDTH, 32, register data width
ZERO_HARDWIRED, 0, if 1 then register 0 always reads 0 and writes to it are discarded at commit

Ports:
CLK  in  1  clock; all state updates on posedge
RESET_N  in  1  synchronous active-low reset
WB_VALID  in  1  writeback request valid
WB_READY  out  1  FIFO can accept a request this cycle
WB_REG  in  5  destination register index
WB_DATA  in  WIDTH  destination data
DRAIN_EN  in  1  permits commit of the FIFO head this cycle
ReadReg1  in  5  read port 1 index
ReadReg2  in  5  read port 2 index
A  out  WIDTH  read port 1 data (committed array contents)
B  out  WIDTH  read port 2 data (committed array contents)
HAZARD_A  out  1  some FIFO entry targets ReadReg1
HAZARD_B  out  1  some FIFO entry targets ReadReg2
FIFO_COUNT  out  log2(DEPTH)+1  number of buffered entries

Behaviour:
- Reset: sampled at posedge when RESET_N=0.
  - All 32 registers cleared to 0; FIFO emptied (FIFO_COUNT=0); WB_READY=1 after the reset cycle.
  - HAZARD_A and HAZARD_B are 0.
  - A push or commit presented in a reset cycle is ignored.
  - Reset mid-operation discards all pending entries; none are committed.
- Push: occurs at posedge when WB_VALID=1 and WB_READY=1. Entry {WB_REG, WB_DATA} is appended at the tail.
- WB_READY = (FIFO_COUNT != DEPTH). It is combinational from FIFO state only and does not depend on DRAIN_EN.
- A request with WB_VALID=1 and WB_READY=0 is neither accepted nor lost. The producer holds it, and it is accepted on the first cycle WB_READY=1.
- Commit: occurs at posedge when DRAIN_EN=1 and FIFO_COUNT>0.
  - The head entry is written into the array and popped; at most one commit per cycle.
  - Commit latency: a request pushed at edge N into an empty FIFO is committed at edge N+1 if DRAIN_EN=1; A/B show the new value after edge N+1.
- Simultaneous push and commit: allowed whenever WB_READY=1. FIFO_COUNT is unchanged.
  - When full, no push occurs even if a commit happens in the same cycle (no same-cycle slot reuse).
- Count arithmetic: FIFO_COUNT +1 on push only, -1 on commit only, unchanged on both or neither. Pointers wrap modulo DEPTH.
- Ordering: commits occur in strict push order. Multiple pending writes to the same register commit in order, so the last one pushed wins.
- Read ports:
  - A = REGS[ReadReg1] and B = REGS[ReadReg2], combinational, with no bypass from the FIFO.
  - A write committing at an edge is visible on A/B only after that edge.
  - ReadReg1 == ReadReg2 is legal; A and B are then equal.
- Hazards: HAZARD_A is 1 iff any valid FIFO entry (including the head being committed this cycle) has index == ReadReg1. HAZARD_B is the same for ReadReg2. Both are combinational.
- ZERO_HARDWIRED=1:
  - Reading index 0 returns 0 and never raises a hazard.
  - A write to index 0 is accepted and occupies a FIFO slot, but its commit leaves the array unchanged.
- ZERO_HARDWIRED=0: register 0 is an ordinary register.

Test Plan:
- Reset, then push {REG=2, DATA=0x1} with DRAIN_EN=1 and ReadReg1=2 → after the push edge HAZARD_A=1, A=0; after the next edge A=0x1, HAZARD_A=0, FIFO_COUNT=0.
- DRAIN_EN=0; push 4 entries {3,0xA},{4,0xB},{5,0xC},{6,0xD} → FIFO_COUNT=4, WB_READY=0. A fifth request {7,0xE} is held, and is accepted one cycle after DRAIN_EN=1. Final contents: R3=0xA, R4=0xB, R5=0xC, R6=0xD, R7=0xE.
- DRAIN_EN=1; push {9,0x5} then {9,0x7} on consecutive cycles with ReadReg2=9 → B sequence 0, 0x5, 0x7. HAZARD_B stays 1 until the 0x7 entry commits.
- FIFO holding 2 entries, push and commit in the same cycle → FIFO_COUNT stays 2. Continuing for 2*DEPTH+1 cycles exercises pointer wrap with data committed in order.
- DRAIN_EN=0 with 3 pending entries, then RESET_N=0 for one cycle → FIFO_COUNT=0 and all registers read 0. No pending entry is committed after DRAIN_EN=1.
- ZERO_HARDWIRED=1: push {0,0xFFFF} and commit, ReadReg1=0 → A=0 and HAZARD_A=0 throughout. With ZERO_HARDWIRED=0, the same stimulus gives A=0xFFFF.
